mem_access: RTL and testbench

Memory-access (MEM) stage of the 5-stage pipeline, directly downstream of the execute stage. Takes the ALU result as the data address and the rs2 operand as store data. Performs loads and stores over a request/acknowledge data-memory port, aligns and sign/zero-extends load data, and presents a registered result to write-back. Stalls the upstream stages while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 5-stage pipeline.
// Non-memory results pass to write-back with one cycle of latency. Loads and
// stores go out over a registered request/acknowledge data-memory port, and
// the upstream stages are stalled while a transaction is outstanding.
// A transaction is abandoned after ACK_TIMEOUT cycles without an acknowledge.
// Optional feature: define MEM_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with a one-cycle misaligned_o flag. When it is undefined, the low
// address bits are ignored for half/word accesses.
module mem_access #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data2_i,
  input  logic [4:0]  write_reg_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_reg_o,
  output logic        wb_reg_write_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_ACCESS = 1'b1;

  // Count value seen in the last ACCESS cycle before the wait is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic        state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        req_q,       req_d;
  logic        we_q,        we_d;
  logic [31:0] addr_q,      addr_d;
  logic [3:0]  be_q,        be_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [1:0]  off_q,       off_d;
  logic [2:0]  funct3_q,    funct3_d;
  logic [4:0]  rd_q,        rd_d;
  logic        rw_q,        rw_d;
  logic        load_q,      load_d;
  logic        wb_valid_q,  wb_valid_d;
  logic [31:0] wb_data_q,   wb_data_d;
  logic [4:0]  wb_reg_q,    wb_reg_d;
  logic        wb_rw_q,     wb_rw_d;
  logic        err_q,       err_d;

  logic [1:0]  in_off;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;

  // Byte-lane enables and replicated store data for the incoming access.
  always_comb begin
    in_off   = alu_result_i[1:0];
    in_be    = 4'b1111;
    in_wdata = read_data2_i;
    case (funct3_i[1:0])
      2'b00: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{read_data2_i[7:0]}};
      end
      2'b01: begin
        in_be    = 4'b0011 << {in_off[1], 1'b0};
        in_wdata = {2{read_data2_i[15:0]}};
      end
      default: begin
        in_be    = 4'b1111;
        in_wdata = read_data2_i;
      end
    endcase
  end

  // Select and extend the loaded byte/half using the registered offset and size.
  always_comb begin
    rdata_shifted = dmem_rdata_i >> {off_q, 3'b000};
    rdata_half    = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_half[15]}}, rdata_half};
      3'b101:  load_ext = {16'h0000, rdata_half};
      default: load_ext = dmem_rdata_i;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic in_misaligned;

  // Half accesses need an even address; word accesses need a 4-byte aligned one.
  always_comb begin
    in_misaligned = ((funct3_i[1:0] == 2'b01) && in_off[0]) ||
                    (funct3_i[1] && (in_off != 2'b00));
  end
`endif

  // Next-state logic: accept ops in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    load_d     = load_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_reg_d   = wb_reg_q;
    wb_rw_d    = wb_rw_q;
    err_d      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d      = 1'b0;
`endif
    case (state_q)
      STATE_IDLE: begin
        if (valid_i) begin
          if (mem_read_i || mem_write_i) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (in_misaligned) begin
              mis_d      = 1'b1;
              wb_valid_d = 1'b1;
              wb_reg_d   = write_reg_i;
              wb_rw_d    = 1'b0;
            end else begin
`else
            begin
`endif
              state_d  = STATE_ACCESS;
              cnt_d    = 8'd0;
              req_d    = 1'b1;
              we_d     = mem_write_i;
              addr_d   = {alu_result_i[31:2], 2'b00};
              be_d     = in_be;
              wdata_d  = in_wdata;
              off_d    = in_off;
              funct3_d = funct3_i;
              rd_d     = write_reg_i;
              rw_d     = reg_write_i;
              load_d   = mem_read_i;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_i;
            wb_reg_d   = write_reg_i;
            wb_rw_d    = reg_write_i;
          end
        end
      end
      default: begin
        if (dmem_ack_i) begin
          // Ack wins over a timeout landing in the same cycle.
          state_d    = STATE_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = rd_q;
          if (load_q) begin
            wb_data_d = load_ext;
            wb_rw_d   = rw_q;
          end else begin
            wb_rw_d   = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = STATE_IDLE;
          req_d      = 1'b0;
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
          wb_reg_d   = rd_q;
          wb_rw_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= STATE_IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      off_q      <= 2'd0;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_reg_q   <= 5'd0;
      wb_rw_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_reg_q   <= wb_reg_d;
      wb_rw_q    <= wb_rw_d;
      err_q      <= err_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle misaligned-access flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
  assign misaligned_o = mis_q;
`else
  assign misaligned_o = 1'b0;
`endif

  assign stall_o        = (state_q == STATE_ACCESS);
  assign dmem_req_o     = req_q;
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = wdata_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_data_o      = wb_data_q;
  assign wb_reg_o       = wb_reg_q;
  assign wb_reg_write_o = wb_rw_q;
  assign bus_err_o      = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access. Expected write-back results are pushed
// to a scoreboard when an op is issued and popped when wb_valid_o appears.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] read_data2_i;
  logic [4:0]  write_reg_i;
  logic        reg_write_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_reg_o;
  logic        wb_reg_write_o;
  logic        misaligned_o;
  logic        bus_err_o;

  always #5 clk_i = ~clk_i;

  mem_access #(.ACK_TIMEOUT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i),
    .alu_result_i(alu_result_i), .read_data2_i(read_data2_i),
    .write_reg_i(write_reg_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o),
    .wb_reg_write_o(wb_reg_write_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;   // which wb_data_o bits are defined for this result
    logic        chk_rd;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rdst, input logic rw);
    valid_i      = 1'b1;
    mem_read_i   = rd_en;
    mem_write_i  = wr_en;
    funct3_i     = f3;
    alu_result_i = addr;
    read_data2_i = wd;
    write_reg_i  = rdst;
    reg_write_i  = rw;
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] m, input logic chk_rd,
                      input logic [4:0] r, input logic rw, input logic err, input logic mis);
    exp_t e;
    e.data = d; e.mask = m; e.chk_rd = chk_rd; e.rd = r;
    e.rw = rw; e.err = err; e.mis = mis;
    sb_q.push_back(e);
  endtask

  // Called at the falling edge of the first ACCESS cycle: holds ack low for
  // `waits` cycles, then acks with rdata; counts stall cycles seen meanwhile.
  task automatic serve(input int waits, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    for (int i = 0; i <= waits; i++) begin
      if (stall_o) stalls++;
      if (i == waits) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
      end
      @(negedge clk_i);
    end
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    total++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_valid_o,
         wb_data_o, wb_reg_o, wb_reg_write_o, misaligned_o, bus_err_o} !== '0)
      $display("FAIL reset_values: req=%b stall=%b wb_valid=%b wb_data=%h addr=%h, required all zero",
               dmem_req_o, stall_o, wb_valid_o, wb_data_o, dmem_addr_o);
    else passed++;
    reset_i = 1'b1;
  endtask

  task automatic test_alu_ops();
    exp_t e;
    logic stall_seen;
    stall_seen = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    push(32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    stall_seen |= stall_o;
    drive(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd7, 1'b0);
    push(32'h0000_0055, 32'hFFFF_FFFF, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (!wb_valid_o || sb_q.size() == 0)
        $display("FAIL alu_wb%0d: wb_valid=%b queued=%0d, required wb_valid=1", k, wb_valid_o, sb_q.size());
      else begin
        e = sb_q.pop_front();
        if ({wb_data_o, wb_reg_o, wb_reg_write_o, bus_err_o} !== {e.data, e.rd, e.rw, e.err})
          $display("FAIL alu_wb%0d: data=%h rd=%0d rw=%b, required data=%h rd=%0d rw=%b",
                   k, wb_data_o, wb_reg_o, wb_reg_write_o, e.data, e.rd, e.rw);
        else passed++;
      end
      if (k == 0) begin
        @(negedge clk_i);
        stall_seen |= stall_o;
      end
    end
    idle_inputs();
    @(negedge clk_i);
    stall_seen |= stall_o;
    total++;
    if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h0000_0055 || wb_reg_o !== 5'd7)
      $display("FAIL alu_idle_hold: wb_valid=%b data=%h rd=%0d, required 0 00000055 7",
               wb_valid_o, wb_data_o, wb_reg_o);
    else passed++;
    total++;
    if (stall_seen !== 1'b0) $display("FAIL alu_no_stall: stall seen=%b, required 0", stall_seen);
    else passed++;
  endtask

  task automatic test_store_byte();
    exp_t e;
    int stalls;
    drive(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd8, 1'b1);
    push(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    idle_inputs();
    total++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !==
        {1'b1, 1'b1, 32'h0000_0100, 4'b1000, 32'hDDDD_DDDD})
      $display("FAIL sb_request: req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 00000100 1000 dddddddd",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o);
    else passed++;
    serve(2, 32'h0, stalls);
    total++;
    if (stalls != 3) $display("FAIL sb_stall_cycles: got %0d, required 3", stalls);
    else passed++;
    total++;
    if (stall_o !== 1'b0 || dmem_req_o !== 1'b0)
      $display("FAIL sb_release: stall=%b req=%b, required 0 0", stall_o, dmem_req_o);
    else passed++;
    total++;
    if (!wb_valid_o || sb_q.size() == 0)
      $display("FAIL sb_wb: wb_valid=%b queued=%0d, required wb_valid=1", wb_valid_o, sb_q.size());
    else begin
      e = sb_q.pop_front();
      if ({wb_reg_write_o, bus_err_o} !== {e.rw, e.err})
        $display("FAIL sb_wb: rw=%b err=%b, required rw=%b err=%b", wb_reg_write_o, bus_err_o, e.rw, e.err);
      else passed++;
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
    logic [31:0] adr_t [6] = '{32'h102, 32'h102, 32'h106, 32'h106, 32'h108, 32'h10C};
    logic [31:0] rd_t  [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000,
                               32'hCAFE_F00D, 32'h1234_5678};
    logic [31:0] exp_t_[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                               32'hCAFE_F00D, 32'h1234_5678};
    exp_t e;
    int stalls;
    logic [3:0] be_exp;
    logic [1:0] o;
    for (int i = 0; i < 6; i++) begin
      o = adr_t[i][1:0];
      if (f3_t[i][1:0] == 2'b00)      be_exp = 4'b0001 << o;
      else if (f3_t[i][1:0] == 2'b01) be_exp = 4'b0011 << (o[1] ? 2 : 0);
      else                            be_exp = 4'b1111;
      drive(1'b1, 1'b0, f3_t[i], adr_t[i], 32'h0, 5'(10 + i), 1'b1);
      push(exp_t_[i], 32'hFFFF_FFFF, 1'b1, 5'(10 + i), 1'b1, 1'b0, 1'b0);
      @(negedge clk_i);
      idle_inputs();
      total++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o} !== {1'b1, 1'b0, adr_t[i] & ~32'h3, be_exp})
        $display("FAIL load%0d_request: req=%b we=%b addr=%h be=%b, required 1 0 %h %b",
                 i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, adr_t[i] & ~32'h3, be_exp);
      else passed++;
      serve(i % 2, rd_t[i], stalls);
      total++;
      if (!wb_valid_o || sb_q.size() == 0)
        $display("FAIL load%0d_wb: wb_valid=%b queued=%0d, required wb_valid=1", i, wb_valid_o, sb_q.size());
      else begin
        e = sb_q.pop_front();
        if ({wb_data_o, wb_reg_o, wb_reg_write_o} !== {e.data, e.rd, e.rw})
          $display("FAIL load%0d_wb: data=%h rd=%0d rw=%b, required data=%h rd=%0d rw=%b",
                   i, wb_data_o, wb_reg_o, wb_reg_write_o, e.data, e.rd, e.rw);
        else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int reqs;
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9, 1'b1);
    push(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    idle_inputs();
    reqs = 0;
    while (dmem_req_o && reqs < 20) begin
      reqs++;
      @(negedge clk_i);
    end
    total++;
    if (reqs != 4) $display("FAIL timeout_req_cycles: got %0d, required 4", reqs);
    else passed++;
    total++;
    if (!wb_valid_o || sb_q.size() == 0)
      $display("FAIL timeout_wb: wb_valid=%b queued=%0d, required wb_valid=1", wb_valid_o, sb_q.size());
    else begin
      e = sb_q.pop_front();
      if ({wb_reg_write_o, bus_err_o, stall_o} !== {e.rw, e.err, 1'b0})
        $display("FAIL timeout_wb: rw=%b bus_err=%b stall=%b, required rw=0 bus_err=1 stall=0",
                 wb_reg_write_o, bus_err_o, stall_o);
      else passed++;
    end
    @(negedge clk_i);
    total++;
    if (bus_err_o !== 1'b0 || wb_valid_o !== 1'b0)
      $display("FAIL timeout_pulse: bus_err=%b wb_valid=%b, required 0 0", bus_err_o, wb_valid_o);
    else passed++;
  endtask

  task automatic test_misaligned();
    exp_t e;
    int stalls;
    drive(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd4, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    push(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    idle_inputs();
    total++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL misalign_no_req: req=%b stall=%b, required 0 0", dmem_req_o, stall_o);
    else passed++;
    total++;
    if (!wb_valid_o || sb_q.size() == 0)
      $display("FAIL misalign_wb: wb_valid=%b queued=%0d, required wb_valid=1", wb_valid_o, sb_q.size());
    else begin
      e = sb_q.pop_front();
      if ({misaligned_o, wb_reg_write_o, bus_err_o} !== {e.mis, e.rw, e.err})
        $display("FAIL misalign_wb: mis=%b rw=%b err=%b, required mis=1 rw=0 err=0",
                 misaligned_o, wb_reg_write_o, bus_err_o);
      else passed++;
    end
    @(negedge clk_i);
    total++;
    if (misaligned_o !== 1'b0) $display("FAIL misalign_pulse: mis=%b, required 0", misaligned_o);
    else passed++;
`else
    push(32'hFFFF_BEEF, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    idle_inputs();
    total++;
    if ({dmem_req_o, dmem_addr_o, dmem_be_o, misaligned_o} !== {1'b1, 32'h0000_0100, 4'b0011, 1'b0})
      $display("FAIL misalign_request: req=%b addr=%h be=%b mis=%b, required 1 00000100 0011 0",
               dmem_req_o, dmem_addr_o, dmem_be_o, misaligned_o);
    else passed++;
    serve(0, 32'h0000_BEEF, stalls);
    total++;
    if (!wb_valid_o || sb_q.size() == 0)
      $display("FAIL misalign_wb: wb_valid=%b queued=%0d, required wb_valid=1", wb_valid_o, sb_q.size());
    else begin
      e = sb_q.pop_front();
      if ({wb_data_o, wb_reg_o, wb_reg_write_o} !== {e.data, e.rd, e.rw})
        $display("FAIL misalign_wb: data=%h rd=%0d rw=%b, required data=%h rd=%0d rw=%b",
                 wb_data_o, wb_reg_o, wb_reg_write_o, e.data, e.rd, e.rw);
      else passed++;
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
    @(negedge clk_i);
    idle_inputs();
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    total++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_valid_o,
         wb_data_o, wb_reg_o, wb_reg_write_o, misaligned_o, bus_err_o} !== '0)
      $display("FAIL reset_mid_access: req=%b stall=%b wb_data=%h addr=%h, required all zero",
               dmem_req_o, stall_o, wb_data_o, dmem_addr_o);
    else passed++;
    @(negedge clk_i);
    reset_i      = 1'b1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    total++;
    if (wb_valid_o !== 1'b0 || stall_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_data_o !== 32'h0)
      $display("FAIL late_ack_ignored: wb_valid=%b stall=%b req=%b wb_data=%h, required 0 0 0 0",
               wb_valid_o, stall_o, dmem_req_o, wb_data_o);
    else passed++;
    total++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drained: %0d left, required 0", sb_q.size());
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_i      = 1'b0;
    valid_i      = 1'b0;
    alu_result_i = 32'h0;
    read_data2_i = 32'h0;
    write_reg_i  = 5'd0;
    reg_write_i  = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    funct3_i     = 3'b000;
    dmem_rdata_i = 32'h0;
    dmem_ack_i   = 1'b0;
    test_reset();
    @(negedge clk_i);
    test_alu_ops();
    test_store_byte();
    test_loads();
    test_timeout();
    test_misaligned();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
